// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_pkg
//  Description : Shared pipeline constants: NOP encoding, stall-vector bit
//                indices and default address/data widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

   // Default widths for fetch-side address and instruction buses
   localparam int DEF_AW = 32;
   localparam int DEF_DW = 32;

   // ADDI x0, x0, 0 - the canonical bubble instruction
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // Bit positions within the 6-bit pipeline stall vector
   localparam int STALL_W   = 6;
   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_WB  = 5;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small synchronous FIFO with registered occupancy count.
//                Simultaneous push and pop is allowed in every state; a push
//                into a full FIFO without a pop, or a pop from an empty FIFO,
//                is ignored. Flush empties the FIFO and wins over push.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
   import rv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             wdata,
   input  logic                         pop,
   output logic [WIDTH-1:0]             rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   // A pop frees a slot in the same cycle, so a full FIFO may still accept
   assign w_do_pop  = pop & (r_count != '0);
   assign w_do_push = push & ((r_count != CW'(DEPTH)) | w_do_pop);

   assign rdata = r_mem[r_rd_ptr];
   assign count = r_count;

   // Storage array; no reset needed since count gates every read
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + CW'(1);
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch
//  Description : Instruction fetch stage. Issues one memory request per cycle
//                for the current PC, tracks up to DEPTH requests in flight,
//                buffers returned instructions and presents one {pc, inst}
//                pair per cycle to decode. Back-pressures the PC through
//                stallreq_o and drops all in-flight work on a branch redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
   import rv_pkg::*;
#(
   parameter int AW    = rv_pkg::DEF_AW,
   parameter int DW    = rv_pkg::DEF_DW,
   parameter int DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [AW-1:0]        pc_i,
   input  logic                 right_one_i,
   input  logic [STALL_W-1:0]   stall,
   input  logic                 br,
   output logic                 imem_req_o,
   output logic [AW-1:0]        imem_addr_o,
   input  logic                 imem_gnt_i,
   input  logic                 imem_rvalid_i,
   input  logic [DW-1:0]        imem_rdata_i,
   output logic                 id_valid_o,
   output logic [AW-1:0]        id_pc_o,
   output logic [DW-1:0]        id_inst_o,
   output logic                 stallreq_o
);

   localparam int CW = $clog2(DEPTH+1);

   logic [CW-1:0]     w_out_cnt;
   logic [CW-1:0]     w_q_cnt;
   logic [CW:0]       w_credits;
   logic              w_has_credit;
   logic              w_stall_id;
   logic              w_accept;
   logic              w_rsp;
   logic              w_drop;
   logic              w_keep;
   logic              w_q_empty;
   logic              w_q_push;
   logic              w_q_pop;
   logic              w_bypass;
   logic [AW-1:0]     w_rsp_pc;
   logic [AW+DW-1:0]  w_q_head;
   logic [CW-1:0]     r_discard_cnt;
   logic              w_unused_stall;

   // Only the ID stall bit matters to this stage
   assign w_stall_id     = stall[STALL_ID];
   assign w_unused_stall = ^{stall[STALL_W-1:STALL_ID+1], stall[STALL_ID-1:0]};

   // Credits cover both in-flight requests and buffered instructions, so a
   // response always has a queue slot waiting for it
   assign w_credits    = {1'b0, w_out_cnt} + {1'b0, w_q_cnt};
   assign w_has_credit = (w_credits < (CW+1)'(DEPTH));

   assign imem_req_o  = !rst & right_one_i & !br & w_has_credit;
   assign imem_addr_o = pc_i;
   assign w_accept    = imem_req_o & imem_gnt_i;
   assign stallreq_o  = !rst & right_one_i & !w_accept;

   // A response with nothing outstanding is a protocol violation and ignored
   assign w_rsp  = imem_rvalid_i & (w_out_cnt != '0);
   assign w_drop = w_rsp & (br | (r_discard_cnt != '0));
   assign w_keep = w_rsp & !w_drop;

   // Queue head has priority; bypass only when nothing is buffered ahead
   assign w_q_empty = (w_q_cnt == '0);
   assign w_q_pop   = !br & !w_stall_id & !w_q_empty;
   assign w_bypass  = !br & !w_stall_id & w_q_empty & w_keep;
   assign w_q_push  = w_keep & !w_bypass;

   fetch_fifo #(
      .WIDTH (AW),
      .DEPTH (DEPTH)
   ) u_out_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (1'b0),
      .push  (w_accept),
      .wdata (pc_i),
      .pop   (w_rsp),
      .rdata (w_rsp_pc),
      .count (w_out_cnt)
   );

   fetch_fifo #(
      .WIDTH (AW+DW),
      .DEPTH (DEPTH)
   ) u_inst_queue (
      .clk   (clk),
      .rst   (rst),
      .flush (br),
      .push  (w_q_push),
      .wdata ({w_rsp_pc, imem_rdata_i}),
      .pop   (w_q_pop),
      .rdata (w_q_head),
      .count (w_q_cnt)
   );

   // Count of responses still owed for requests issued before a redirect
   always_ff @(posedge clk) begin
      if (rst) begin
         r_discard_cnt <= '0;
      end else if (br) begin
         r_discard_cnt <= w_out_cnt - CW'(w_rsp);
      end else if (w_drop) begin
         r_discard_cnt <= r_discard_cnt - CW'(1);
      end
   end

   // Decode-facing registers: flush bubble, hold on ID stall, else advance
   always_ff @(posedge clk) begin
      if (rst) begin
         id_valid_o <= 1'b0;
         id_pc_o    <= '0;
         id_inst_o  <= DW'(NOP_INST);
      end else if (br) begin
         id_valid_o <= 1'b0;
         id_inst_o  <= DW'(NOP_INST);
      end else if (!w_stall_id) begin
         if (!w_q_empty) begin
            id_valid_o <= 1'b1;
            id_pc_o    <= w_q_head[AW+DW-1:DW];
            id_inst_o  <= w_q_head[DW-1:0];
         end else if (w_bypass) begin
            id_valid_o <= 1'b1;
            id_pc_o    <= w_rsp_pc;
            id_inst_o  <= imem_rdata_i;
         end else begin
            id_valid_o <= 1'b0;
            id_inst_o  <= DW'(NOP_INST);
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage sitting directly downstream of `program_counter`. Each cycle it turns the current `pc_o`/`right_one_o` pair into an instruction-memory request, tracks up to two in-flight requests, buffers returned instructions, and presents one `{pc, inst}` pair per cycle to the decode (ID) stage. It back-pressures the PC through a stall request and discards all in-flight work on a branch redirect.

## Interface
- `AW`, 32: address width.
- `DW`, 32: instruction width.
- `DEPTH`, 2: instruction queue depth; power of 2, ≥2. Also the maximum number of outstanding requests.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `pc_i`  in  AW: fetch address, driven from `program_counter.pc_o`.
- `right_one_i`  in  1: `pc_i` is a valid fetch address (from `right_one_o`).
- `stall`  in  6: pipeline stall vector; bit 2 = ID stall, the only bit used here.
- `br`  in  1: branch redirect / flush from EX.
- `imem_req_o`  out  1: memory request.
- `imem_addr_o`  out  AW: request address, equal to `pc_i`.
- `imem_gnt_i`  in  1: request accepted this cycle.
- `imem_rvalid_i`  in  1: response valid, returned in request order.
- `imem_rdata_i`  in  DW: response instruction.
- `id_valid_o`  out  1: `id_*` holds a real instruction.
- `id_pc_o`  out  AW: PC of the presented instruction.
- `id_inst_o`  out  DW: presented instruction; NOP when not valid.
- `stallreq_o`  out  1: asks the PC to hold `pc_i`.

## Operation
- Credits are `outstanding + queue_count`, never more than `DEPTH`.
- `imem_req_o = right_one_i & !br & (credits < DEPTH)`. `imem_addr_o = pc_i` (combinational).
- Accept = `imem_req_o & imem_gnt_i`. On accept, `pc_i` is pushed into the outstanding-PC FIFO.
- `stallreq_o = right_one_i & !accept`, so the PC advances only on an accepted fetch.
- Response: `imem_rvalid_i` pops the oldest outstanding PC.
  - If `discard_cnt > 0`, decrement it and drop the response.
  - Otherwise, if the queue is empty and `!stall[2]`, load the `id_*` registers directly (bypass).
  - Otherwise push `{pc, inst}` into the instruction queue.
- ID advance, when `!stall[2]`:
  - Load `id_*` from the queue head and pop it, else from the bypass.
  - If neither source is present, load the bubble: `id_valid_o=0`, `id_inst_o=32'h0000_0013`, `id_pc_o` holds.
- While `stall[2]` is high, `id_*` hold.
- Flush (`br=1`):
  - No request that cycle.
  - Next edge: queue emptied, `id_*` set to bubble (overrides `stall[2]`).
  - `discard_cnt <= outstanding − (imem_rvalid_i ? 1 : 0)`.
  - A response arriving in the `br` cycle is dropped.
  - The outstanding FIFO keeps draining normally.
- Simultaneous push and pop on either FIFO in one cycle is legal; count is unchanged.
- `imem_rvalid_i` with zero outstanding is a protocol violation: ignored, no state change.
- Reset values:
  - All counters and FIFOs empty.
  - `imem_req_o=0`, `stallreq_o=0`, `id_valid_o=0`, `id_pc_o=0`, `id_inst_o=32'h0000_0013`.
  - `imem_addr_o` follows `pc_i`.
- `rst` overrides `br` and any traffic in progress. In-flight responses after reset are treated as protocol violations, so the memory must be reset together with this block.

## Timing
- Request → grant: same cycle (combinational gnt).
- Grant → `imem_rvalid_i`: ≥1 cycle, any latency, in order.
- `imem_rvalid_i` → `id_valid_o`:
  - 1 cycle via bypass (queue empty, ID not stalled).
  - Otherwise, the edge after the entry reaches the head with `!stall[2]`.
- Throughput is one instruction per cycle with a 1-cycle memory and no stalls.
- `br` → bubble on `id_*`: 1 cycle. First refetch request is in the cycle after `br` deasserts.
- `stallreq_o` is combinational from `right_one_i`, `br`, credits and `imem_gnt_i`.

## Structure
- Shared package `rv_pkg` holds:
  - `NOP_INST = 32'h0000_0013`.
  - Stall bit index constants (`STALL_PC=0`, `STALL_IF=1`, `STALL_ID=2`, …).
  - `AW`/`DW` defaults.
- One sub-module, `fetch_fifo` (parameterised width/depth, synchronous, registered count). It is instantiated twice: outstanding PCs (AW bits) and instruction queue (AW+DW bits).
- Credit and discard logic lives in `inst_fetch`.

## Test plan
- Reset: assert `rst` 2 cycles with `right_one_i=1`. Require `imem_req_o=0`, `id_valid_o=0` and `id_inst_o=0x13` during and after reset.
- Streaming:
  - Stimulus: 1-cycle memory, `gnt` always 1; PC 0x0,0x4,0x8; rdata = 0x100+addr.
  - Require `id_pc_o`/`id_inst_o` to be 0x0/0x100, 0x4/0x104, 0x8/0x108 on consecutive cycles, starting 2 cycles after the first request.
- Back-pressure:
  - Stimulus: hold `stall[2]=1` for 4 cycles.
  - Require at most 2 accepts, then `imem_req_o=0` and `stallreq_o=1`; `id_*` unchanged.
  - On release, no instruction is lost or duplicated.
- Grant stall: `imem_gnt_i=0` for 3 cycles. Require `stallreq_o=1` and `imem_addr_o` stable at 0x10; the fetch completes once `gnt` returns.
- Flush:
  - Stimulus: 3-cycle memory latency, 2 outstanding, pulse `br` while the PC jumps to 0x80.
  - Require both old responses dropped and a bubble on the next cycle. The first valid `id_pc_o` after the flush must be 0x80.
- Flush coincident with response: `br` and `imem_rvalid_i` in the same cycle with 2 outstanding. Require `discard_cnt=1` and the next response dropped.
